// File: rtl/uart_fw_loader.sv
// uart_fw_loader: UART command stream loader packing bytes into 32-bit bus writes.
// Build option LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte per load.
module uart_fw_loader #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    output logic              run,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    // Bytes that fit between BASE_ADDR and the top of the address space.
    localparam logic [63:0] LIMIT = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FLUSH,
        S_REPLY
    } state_t;

    state_t            state_q;
    logic [31:0]       len_q;
    logic [1:0]        lcnt_q;
    logic [31:0]       cnt_q;
    logic [31:0]       asm_q;
    logic              ovf_q;
    logic              err_q;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              run_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              csum_bad_q;
`endif

    logic [31:0]       len_d;
    logic [1:0]        lane_d;
    logic              last_d;
    logic              word_done_d;
    logic              pend_d;
    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        code_d;

    always_comb begin
        len_d       = {rx_data, len_q[31:8]};
        lane_d      = cnt_q[1:0];
        last_d      = (cnt_q == len_q - 32'd1);
        word_done_d = (lane_d == 2'd3) || last_d;
        pend_d      = mem_valid_q && !mem_ready;
        wdata_d     = asm_q;
        wdata_d[8*lane_d +: 8] = rx_data;
        // Lanes 0..lane filled; lane 3 yields a full 0xF mask.
        wstrb_d     = 4'((5'b00010 << lane_d) - 5'd1);
        addr_d      = ADDR_W'(BASE_ADDR + {cnt_q[31:2], 2'b00});
`ifdef LOADER_CHECKSUM_EN
        code_d      = (err_q || ovf_q || csum_bad_q) ? NAK : ACK;
`else
        code_d      = (err_q || ovf_q) ? NAK : ACK;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            lcnt_q      <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            run_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
            csum_bad_q  <= 1'b0;
`endif
        end else begin
            run_q <= 1'b0;
            if (mem_valid_q && mem_ready) begin
                mem_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_LOAD) begin
                            state_q <= S_LEN;
                            lcnt_q  <= '0;
                            len_q   <= '0;
                            err_q   <= 1'b0;
                        end else if (rx_data == CMD_RUN) begin
                            // Reply is raised the cycle after the run pulse.
                            run_q     <= 1'b1;
                            tx_data_q <= ACK;
                            state_q   <= S_REPLY;
                        end else begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= NAK;
                            state_q    <= S_REPLY;
                        end
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        len_q  <= len_d;
                        lcnt_q <= lcnt_q + 2'd1;
                        if (lcnt_q == 2'd3) begin
                            cnt_q   <= '0;
                            asm_q   <= '0;
                            ovf_q   <= ({32'd0, len_d} > LIMIT);
`ifdef LOADER_CHECKSUM_EN
                            sum_q      <= '0;
                            csum_bad_q <= 1'b0;
`endif
                            state_q <= (len_d == 32'd0) ? S_FLUSH : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        cnt_q <= cnt_q + 32'd1;
                        asm_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + rx_data;
`endif
                        if (word_done_d) begin
                            asm_q <= '0;
                            if (!ovf_q) begin
                                if (pend_d) begin
                                    err_q <= 1'b1;
                                end else begin
                                    mem_valid_q <= 1'b1;
                                    mem_addr_q  <= addr_d;
                                    mem_wdata_q <= wdata_d;
                                    mem_wstrb_q <= wstrb_d;
                                end
                            end
                        end
                        if (last_d) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            state_q <= S_FLUSH;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid) begin
                        csum_bad_q <= (rx_data != sum_q);
                        state_q    <= S_FLUSH;
                    end
                end
`endif
                S_FLUSH: begin
                    if (!mem_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= code_d;
                        state_q    <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign run       = run_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_uart_fw_loader.sv
// tb_uart_fw_loader: randomized scoreboard bench for uart_fw_loader.
// Define LOADER_CHECKSUM_EN for both files to cover the checksum build.
`timescale 1ns/1ps
module tb_uart_fw_loader;

    localparam int AW    = 6;
    localparam int BASE  = 0;
    localparam int LIMIT = (1 << AW) - BASE;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b0;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready = 1'b0;
    logic          run;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    uart_fw_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .run(run), .busy(busy), .err(err)
    );

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int rmode = 0;
    int exp_runs = 0;
    int got_runs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready generators; mode 0 guarantees mem_ready at least every third cycle.
    always @(posedge clk) begin
        cyc++;
        #1;
        tx_ready = ($urandom_range(0, 2) != 0);
        if (rmode == 1) mem_ready = 1'b1;
        else if (rmode == 2) mem_ready = 1'b0;
        else mem_ready = ($urandom_range(0, 1) == 1) || (cyc % 3 == 0);
    end

    logic       p_mv = 1'b0;
    logic       p_tv = 1'b0;
    logic       p_run = 1'b0;
    wr_t        p_wr;
    logic [7:0] p_td = 8'h00;
    wr_t        mon_e;
    logic [7:0] mon_t;

    always @(negedge clk) begin
        if (!reset) begin
            if (p_mv) chk("mem_hold", 64'({mem_valid, mem_addr, mem_wdata, mem_wstrb}), 64'({1'b1, p_wr}));
            if (p_tv) chk("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, p_td}));
            if (p_run) chk("run_width", 64'(run), 64'd0);
            if (run) got_runs++;
            if (mem_valid && mem_ready) begin
                if (exp_wr.size() == 0) begin
                    chk("write_expected", 64'(exp_wr.size()), 64'd1);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("mem_write", 64'({mem_addr, mem_wdata, mem_wstrb}), 64'(mon_e));
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    chk("reply_expected", 64'(exp_tx.size()), 64'd1);
                end else begin
                    mon_t = exp_tx.pop_front();
                    chk("reply", 64'(tx_data), 64'(mon_t));
                end
            end
        end
        p_mv  = mem_valid && !mem_ready && !reset;
        p_wr  = {mem_addr, mem_wdata, mem_wstrb};
        p_tv  = tx_valid && !tx_ready && !reset;
        p_td  = tx_data;
        p_run = run && !reset;
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (t < budget && (exp_tx.size() != 0 || busy)) begin
            @(negedge clk);
            t++;
        end
        chk("reply_in_time", 64'(t < budget), 64'd1);
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Reference: every 4 bytes form one little-endian word at BASE + 4*w.
    task automatic model_load(input byte_q_t d, input int max_words);
        int n = d.size();
        if (n > LIMIT) return;
        for (int w = 0; w * 4 < n && w < max_words; w++) begin
            wr_t e;
            e.addr = AW'(BASE + 4 * w);
            e.data = '0;
            e.strb = '0;
            for (int l = 0; l < 4 && 4 * w + l < n; l++) begin
                e.data[8*l +: 8] = d[4*w+l];
                e.strb[l] = 1'b1;
            end
            exp_wr.push_back(e);
        end
    endtask

    task automatic do_load(input byte_q_t d, input int gap, input bit bad_csum, input bit stall);
        int n = d.size();
        logic [7:0] s = 8'h00;
        bit ack;
        ack = (n <= LIMIT) && !stall;
`ifdef LOADER_CHECKSUM_EN
        if (bad_csum) ack = 1'b0;
`endif
        model_load(d, stall ? 1 : 1 << 30);
        exp_tx.push_back(ack ? 8'h06 : 8'h15);
        send(8'h01, gap);
        chk("busy_in_load", 64'(busy), 64'd1);
        chk("err_cleared", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) send(8'(n >> (8 * i)), gap);
        if (stall) rmode = 2;
        foreach (d[i]) begin
            send(d[i], gap);
            s = 8'(s + d[i]);
        end
        if (stall) begin
            repeat (4) begin @(posedge clk); #1; end
            rmode = 1;
        end
`ifdef LOADER_CHECKSUM_EN
        send(bad_csum ? 8'(s + 8'd1) : s, gap);
`endif
        wait_done(300);
    endtask

    initial begin
        byte_q_t d;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({tx_valid, tx_data, mem_valid, mem_addr, mem_wdata,
            mem_wstrb, run, busy, err}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        rmode = 1;
        d = {};
        for (int i = 0; i < 8; i++) d.push_back(8'(i));
        do_load(d, 2, 1'b0, 1'b0);

        d = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        do_load(d, 2, 1'b0, 1'b0);

        d = {};
        for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
        do_load(d, 2, 1'b0, 1'b1);
        chk("err_sticky", 64'(err), 64'd1);

        exp_tx.push_back(8'h15);
        send(8'h7F, 2);
        wait_done(200);
        exp_runs++;
        exp_tx.push_back(8'h06);
        send(8'h02, 2);
        wait_done(200);
        chk("run_count", 64'(got_runs), 64'(exp_runs));

        d = {};
        do_load(d, 2, 1'b0, 1'b0);

        d = {};
        for (int i = 0; i < LIMIT; i++) d.push_back(8'($urandom));
        do_load(d, 1, 1'b0, 1'b0);
        d.push_back(8'h5A);
        do_load(d, 1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        d = {8'h10, 8'h20};
        do_load(d, 2, 1'b0, 1'b0);
        do_load(d, 2, 1'b1, 1'b0);
`endif

        rmode = 2;
        send(8'h01, 2);
        send(8'h08, 2);
        for (int i = 0; i < 3; i++) send(8'h00, 2);
        for (int i = 0; i < 5; i++) send(8'($urandom), 2);
        chk("pending_before_reset", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_data", 64'({tx_valid, tx_data, mem_valid, mem_addr, mem_wdata,
            mem_wstrb, run, busy, err}), 64'd0);
        reset = 1'b0;
        rmode = 0;
        @(posedge clk); #1;

        for (int it = 0; it < 25; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) begin
                logic [7:0] b = 8'($urandom);
                if (b == 8'h01 || b == 8'h02) b = 8'hA5;
                exp_tx.push_back(8'h15);
                send(b, 3);
                wait_done(200);
            end else if (kind == 1) begin
                exp_runs++;
                exp_tx.push_back(8'h06);
                send(8'h02, 3);
                wait_done(200);
            end else begin
                int n = $urandom_range(0, LIMIT + 6);
                bit bc = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                bc = ($urandom_range(0, 3) == 0);
`endif
                d = {};
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                do_load(d, $urandom_range(6, 9), bc, 1'b0);
            end
        end
        chk("run_count_final", 64'(got_runs), 64'(exp_runs));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
